// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: bus operation codes, stage
// states and datapath widths.
package mem_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  // Encoding 3 is reserved and decoded as MEM_NONE by the stage.
  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LW   = 2'd1,
    MEM_SW   = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: runs one req/ack bus transaction for aligned LW/SW,
// then holds a single registered writeback record on a valid/ready output.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mem_op,
  input  logic [DATA_W-1:0]    in_alu_result,
  input  logic [DATA_W-1:0]    in_store_data,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_reg_we,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [DATA_W-1:0]    bus_wdata,
  input  logic                 bus_ack,
  input  logic [DATA_W-1:0]    bus_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_reg_we,
  output logic                 out_misaligned
);

  mem_state_t            r_state;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_W-1:0]     r_bus_addr;
  logic [DATA_W-1:0]     r_bus_wdata;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic [REG_IDX_W-1:0]  r_out_rd;
  logic                  r_out_reg_we;
  logic                  r_out_misaligned;
  logic                  r_reg_we;
  logic [DATA_W-1:0]     r_alu;

  logic w_in_ready;
  logic w_accept;
  logic w_is_mem;
  logic w_misaligned;

  // The only combinational in->out path: a taken record frees the slot.
  assign w_in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept     = in_valid && w_in_ready;
  assign w_is_mem     = (in_mem_op == MEM_LW) || (in_mem_op == MEM_SW);
  assign w_misaligned = (in_alu_result[1:0] != 2'b00);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_bus_req        <= 1'b0;
      r_bus_we         <= 1'b0;
      r_bus_addr       <= '0;
      r_bus_wdata      <= '0;
      r_out_valid      <= 1'b0;
      r_out_data       <= '0;
      r_out_rd         <= '0;
      r_out_reg_we     <= 1'b0;
      r_out_misaligned <= 1'b0;
      r_reg_we         <= 1'b0;
      r_alu            <= '0;
    end else begin
      case (r_state)
        BUS: begin
          if (bus_ack) begin
            r_state          <= DONE;
            r_bus_req        <= 1'b0;
            r_out_valid      <= 1'b1;
            r_out_misaligned <= 1'b0;
            // bus_we doubles as the captured "this is a store" flag.
            r_out_data       <= r_bus_we ? r_alu : bus_rdata;
            r_out_reg_we     <= r_bus_we ? 1'b0 : r_reg_we;
          end
        end
        default: begin
          if ((r_state == DONE) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            r_out_rd <= in_rd;
            r_reg_we <= in_reg_we;
            r_alu    <= in_alu_result;
            if (w_is_mem && !w_misaligned) begin
              r_state     <= BUS;
              r_bus_req   <= 1'b1;
              r_bus_we    <= (in_mem_op == MEM_SW);
              r_bus_addr  <= in_alu_result[ADDR_W-1:0];
              r_bus_wdata <= in_store_data;
              r_out_valid <= 1'b0;
            end else begin
              // Register op, or a suppressed misaligned access.
              r_state          <= DONE;
              r_out_valid      <= 1'b1;
              r_out_data       <= in_alu_result;
              r_out_reg_we     <= in_reg_we && !w_is_mem;
              r_out_misaligned <= w_is_mem;
            end
          end
        end
      endcase
    end
  end

  assign in_ready       = w_in_ready;
  assign bus_req        = r_bus_req;
  assign bus_we         = r_bus_we;
  assign bus_addr       = r_bus_addr;
  assign bus_wdata      = r_bus_wdata;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_rd         = r_out_rd;
  assign out_reg_we     = r_out_reg_we;
  assign out_misaligned = r_out_misaligned;

endmodule

// File: doc/mem_stage.md
# mem_stage

- Memory-access stage directly downstream of the core ALU.
- Consumes the ALU result as either a word address (load/store) or a pass-through value (register ops).
- For loads and stores it runs one transaction on a simple req/ack data bus; it then presents a single buffered writeback record to the next stage with a valid/ready handshake.
- One instruction in flight; the stage stalls upstream while busy.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width; `alu_result[ADDR_W-1:0]` drives `bus_addr`.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream record valid.
- `in_ready`  out  1  stage can accept a record this cycle.
- `in_mem_op`  in  2  `MEM_NONE`=0, `MEM_LW`=1, `MEM_SW`=2; 3 is reserved and treated as `MEM_NONE`.
- `in_alu_result`  in  32  ALU result: address, or writeback value.
- `in_store_data`  in  32  store data for `MEM_SW`.
- `in_rd`  in  5  destination register.
- `in_reg_we`  in  1  destination write enable.
- `bus_req`  out  1  transaction request; held until ack.
- `bus_we`  out  1  1=write, 0=read.
- `bus_addr`  out  ADDR_W  word-aligned byte address.
- `bus_wdata`  out  32  write data.
- `bus_ack`  in  1  transaction complete; `bus_rdata` valid this cycle.
- `bus_rdata`  in  32  read data.
- `out_valid`  out  1  writeback record valid.
- `out_ready`  in  1  downstream accepts the record.
- `out_data`  out  32  writeback value.
- `out_rd`  out  5  destination register.
- `out_reg_we`  out  1  register write enable.
- `out_misaligned`  out  1  LW/SW had `addr[1:0] != 0`; access suppressed.

## Operation
States: `IDLE`, `BUS`, `DONE`.

- **Accept:** occurs when `in_valid && in_ready`.
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - Accepting captures all `in_*` fields into internal registers.
- **On accept:**
  - `MEM_NONE`/reserved → `DONE`, with `out_data=alu_result`, `out_reg_we=in_reg_we`, `out_misaligned=0`.
  - LW/SW with `alu_result[1:0]!=0` → `DONE`, with `out_misaligned=1`, `out_reg_we=0`, `out_data=alu_result`; no bus request.
  - LW/SW aligned → `BUS`.
- **`BUS`:**
  - `bus_req=1`; `bus_we=(op==MEM_SW)`; `bus_addr`/`bus_wdata` come from the captured registers and stay stable while `bus_req` is held.
  - On `bus_ack`, go to `DONE`:
    - LW: `out_data=bus_rdata` (captured at the ack edge), `out_reg_we=captured reg_we`.
    - SW: `out_data=alu_result`, `out_reg_we=0`.
- **`DONE`:**
  - `out_valid=1`; output fields are constant until taken.
  - On `out_ready`: if a new record is accepted in the same cycle, take the accept path above; otherwise go to `IDLE`.
- **Spurious ack:** `bus_ack` in `IDLE` or `DONE` is ignored.
- **`out_rd`:** always the captured `in_rd`.

## Timing
- **Reset:**
  - `state=IDLE`, `in_ready=1`.
  - `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`.
  - `out_valid=0`, `out_data=0`, `out_rd=0`, `out_reg_we=0`, `out_misaligned=0`.
- **Reset mid-`BUS`:** `bus_req` falls at that edge; a late `bus_ack` is ignored.
- **`MEM_NONE`:** accept at edge N; `out_valid` is high from N (visible in cycle N+1).
- **Bus op:**
  - `bus_req` rises after the accept edge.
  - Ack in the first `BUS` cycle gives `out_valid` one cycle later.
  - Minimum load latency is 2 cycles, accept to `out_valid`.
- **Back-to-back:** with `out_ready` held high, `MEM_NONE` records sustain 1 per cycle.
- **Outputs:** `bus_*` and `out_*` are registered.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`; no other combinational in→out paths exist.

## Structure
- Package `mem_pkg`: `mem_op_t` enum (`MEM_NONE`/`MEM_LW`/`MEM_SW`), `mem_state_t` enum (`IDLE`/`BUS`/`DONE`), width constants for register index (5) and data (32).
- `core.svh` ALU op constants are not required here.
- Single module; no sub-module. The alignment check is a local expression.

## Test plan
- **Register op:** `MEM_NONE`, `alu_result=0x1234`, `rd=3`, `reg_we=1`, `out_ready=1` → next cycle `out_valid=1`, `out_data=0x1234`, `out_rd=3`, `out_reg_we=1`; no `bus_req`.
- **Load:** LW `addr=0x100`, ack after 3 cycles with `rdata=0xDEADBEEF` → `bus_req` high for exactly 3 cycles with `bus_we=0`, `bus_addr=0x100`; `out_data=0xDEADBEEF`, `out_reg_we=1`.
- **Store:** SW `addr=0x200`, `store_data=0xA5A5A5A5`, ack immediately → `bus_we=1`, `bus_wdata=0xA5A5A5A5`; `out_valid` with `out_reg_we=0`.
- **Misaligned:** LW `addr=0x102` → no `bus_req`; `out_misaligned=1`, `out_reg_we=0`, `out_data=0x102`.
- **Backpressure and throughput:** `out_ready=0` for 4 cycles with a second record pending → `in_ready=0`, outputs stable; when `out_ready` rises the second record is accepted that same cycle; 8 back-to-back `MEM_NONE` records complete in 8 cycles.
- **Reset mid-transaction:** reset asserted in `BUS`, then `bus_ack` pulsed → `bus_req=0` and `out_valid=0` after reset; the ack has no effect; a following LW completes normally.
